// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program-counter register and next-PC sequencer; turns FENCE into
//            a bounded pause and ECALL/EBREAK or a misaligned redirect into a
//            halt. Optional retired-instruction counter under PC_INSTRET_EN.
// Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC           = 32'h0000_0000,
    parameter int unsigned FENCE_STALL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_ready,
    input  logic [6:0]  opcode,
    input  logic        take_branch,
    input  logic [31:0] branch_target,
    input  logic        jalr,
    input  logic [31:0] jalr_target,
    input  logic        resume,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_en,
    output logic        halted,
    output logic        misaligned,
    output logic [31:0] instret
);

    localparam logic [1:0]  c_st_run   = 2'd0;
    localparam logic [1:0]  c_st_fence = 2'd1;
    localparam logic [1:0]  c_st_halt  = 2'd2;

    localparam logic [6:0]  c_op_system = 7'b1110011;
    localparam logic [6:0]  c_op_fence  = 7'b0001111;

    localparam int unsigned c_stall    = (FENCE_STALL_CYCLES == 0) ? 1 : FENCE_STALL_CYCLES;
    localparam logic [31:0] c_cnt_init = 32'(c_stall - 1);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_cnt;
    logic        r_misaligned;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic        w_retire;

    assign w_pc_plus4 = r_pc + 32'd4;
    // JALR outranks a conditional branch; its LSB is always cleared
    assign w_target   = jalr ? {jalr_target[31:1], 1'b0} : branch_target;
    assign w_retire   = (r_state == c_st_run) && imem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_run;
            r_pc         <= RESET_PC;
            r_cnt        <= 32'd0;
            r_misaligned <= 1'b0;
        end else begin
            case (r_state)
                c_st_run: begin
                    if (imem_ready) begin
                        if (opcode == c_op_system) begin
                            r_state <= c_st_halt;
                        end else if (opcode == c_op_fence) begin
                            r_state <= c_st_fence;
                            r_cnt   <= c_cnt_init;
                        end else if (jalr || take_branch) begin
                            if (w_target[1]) begin
                                r_misaligned <= 1'b1;
                                r_state      <= c_st_halt;
                            end else begin
                                r_pc <= w_target;
                            end
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
                    end
                end
                c_st_fence: begin
                    if (r_cnt == 32'd0) begin
                        r_pc    <= w_pc_plus4;
                        r_state <= c_st_run;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                c_st_halt: begin
                    if (resume) begin
                        r_pc         <= w_pc_plus4;
                        r_misaligned <= 1'b0;
                        r_state      <= c_st_run;
                    end
                end
                default: r_state <= c_st_run;
            endcase
        end
    end

`ifdef PC_INSTRET_EN
    logic [31:0] r_instret;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= 32'd0;
        end else if (w_retire) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign instret = r_instret;
`else
    logic w_unused;
    assign w_unused = w_retire;
    assign instret  = 32'd0;
`endif

    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign fetch_en   = (r_state == c_st_run);
    assign halted     = (r_state == c_st_halt);
    assign misaligned = r_misaligned;

endmodule
`default_nettype wire
